// File: rtl/add_seq_x64_pkg.sv
// Shared types for the sequential adder: FSM states, default sizing and the
// condition-flag bundle also used by the Execute-stage condition-code register.
package add_seq_x64_pkg;

  localparam int DEF_W     = 64;
  localparam int DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic cf;
    logic of;
    logic zf;
    logic sf;
  } flags_t;

endpackage

// File: rtl/add_seq_x64_if.sv
// Operand/result handshake bundle for add_seq_x64; the master drives operands
// and consumes the result, the slave is the adder.
interface add_seq_x64_if #(
  parameter int W = 64
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         CF;
  logic         OF;
  logic         ZF;
  logic         SF;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, CF, OF, ZF, SF
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, CF, OF, ZF, SF
  );

endinterface

// File: rtl/add_seq_x64_add_chunk.sv
// CHUNK-bit ripple of full adders; also exposes the carry into the top bit so
// the last chunk can form the signed-overflow flag.
module add_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  // NOTE: blocking assignments here are deliberate -- the carry variable must
  // ripple bit-to-bit within a single evaluation of this combinational block.
  always_comb begin
    logic c;
    c        = cin;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb_in = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/add_seq_x64.sv
// Multi-cycle two's-complement adder: one CHUNK-bit slice per clock with the
// carry held in a register, then sum and y86 flags presented until taken.
module add_seq_x64
  import add_seq_x64_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic               clk,
  input  logic               rst_n,
  add_seq_x64_if.slave       bus
);

  localparam int NCHUNK = W / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  flags_t             r_flags;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_last;
  int                 w_base;
  logic [CHUNK-1:0]   w_x;
  logic [CHUNK-1:0]   w_y;
  logic [CHUNK-1:0]   w_s;
  logic               w_cout;
  logic               w_c_msb;
  logic [W-1:0]       w_sum_next;

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_last   = (r_cnt == CNT_W'(NCHUNK - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: the default assignment first means no path leaves w_state_next
  // unassigned, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)      w_state_next = RUN;
      RUN:     if (w_last)        w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default:                    w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == IDLE);
    w_out_valid = (r_state == DONE);
  end

  // Slice select for the chunk currently being added; the new chunk is merged
  // into the running sum so the flags see the complete final value.
  always_comb begin
    w_base     = int'(r_cnt) * CHUNK;
    w_x        = r_a[w_base +: CHUNK];
    w_y        = r_b[w_base +: CHUNK];
    w_sum_next = r_sum;
    w_sum_next[w_base +: CHUNK] = w_s;
  end

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .x        (w_x),
    .y        (w_y),
    .cin      (r_carry),
    .s        (w_s),
    .cout     (w_cout),
    .c_msb_in (w_c_msb)
  );

  // NOTE: operand and result registers are reset too; the reset-value
  // contract covers sum and flags, and a uniform async reset keeps one block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_cout;
          if (w_last) begin
            r_flags.cf <= w_cout;
            r_flags.of <= w_cout ^ w_c_msb;
            r_flags.zf <= ~|w_sum_next;
            r_flags.sf <= w_sum_next[W-1];
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.CF        = r_flags.cf;
  assign bus.OF        = r_flags.of;
  assign bus.ZF        = r_flags.zf;
  assign bus.SF        = r_flags.sf;

endmodule

// File: tb/tb_add_seq_x64.sv
// Self-checking bench for add_seq_x64: directed corner cases, subtractor
// round-trips, mid-operation reset and randomized operands against a model.
module tb_add_seq_x64;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  add_seq_x64_if #(.W(64)) bus ();

  add_seq_x64 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 65-bit addition; flags from the sign rules.
  function automatic logic [67:0] ref_add(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] full;
    logic        of;
    full = {1'b0, a} + {1'b0, b};
    of   = (a[63] == b[63]) && (full[63] != a[63]);
    // order {CF, OF, ZF, SF}
    return {full[64], of, (full[63:0] == 64'd0), full[63], full[63:0]};
  endfunction

  function automatic logic [3:0] dut_flags();
    return {bus.CF, bus.OF, bus.ZF, bus.SF};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input int stall, input bit noise);
    logic [67:0] exp;
    logic [63:0] held_sum;
    logic [3:0]  held_flags;
    int          cycles;
    int          waited;
    exp = ref_add(a, b);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 40) begin
      tick();
      waited++;
    end
    check({tag, " in_ready before accept"}, 64'(bus.in_ready), 64'd1);
    tick();  // accept edge E0
    cycles = 0;
    if (!noise) bus.in_valid = 1'b0;
    while (!bus.out_valid && cycles < 40) begin
      if (noise) begin
        bus.a        = {$urandom, $urandom};
        bus.b        = {$urandom, $urandom};
        bus.in_valid = 1'($urandom_range(0, 1));
      end
      tick();
      cycles++;
    end
    bus.in_valid = 1'b0;
    check({tag, " latency"}, 64'(cycles), 64'd8);
    check({tag, " sum"}, bus.sum, exp[63:0]);
    check({tag, " flags CF/OF/ZF/SF"}, 64'(dut_flags()), 64'(exp[67:64]));
    check({tag, " in_ready in DONE"}, 64'(bus.in_ready), 64'd0);
    held_sum   = bus.sum;
    held_flags = dut_flags();
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, " stall hold"},
            {59'(bus.sum ^ held_sum), bus.out_valid, bus.in_ready, dut_flags() ^ held_flags},
            {59'd0, 1'b1, 1'b0, 4'd0});
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " released to IDLE"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
  endtask

  initial begin
    logic [63:0] ra, rb;
    int          saw_valid;
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    #3;
    check("reset in_ready",  64'(bus.in_ready),  64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset sum",       bus.sum,            64'd0);
    check("reset flags",     64'(dut_flags()),   64'd0);
    #20;
    rst_n = 1'b1;
    tick();

    run_op("2811+1012", 64'd2811, 64'd1012, 0, 1'b0);
    run_op("-1243+1234", -64'sd1243, 64'd1234, 0, 1'b1);
    run_op("maxpos+1", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
    run_op("minneg+minneg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5, 1'b0);
    check("minneg sum literal", bus.sum, 64'd0);

    // Subtractor round-trip: (a - b) + b must give back a.
    run_op("rt 4238", 64'd4238 - (-64'sd4238), -64'sd4238, 0, 1'b0);
    check("rt 4238 equals a", bus.sum, 64'd4238);
    run_op("rt max/min", 64'h7FFF_FFFF_FFFF_FFFF - 64'h8000_0000_0000_0000,
           64'h8000_0000_0000_0000, 0, 1'b0);
    check("rt max/min equals a", bus.sum, 64'h7FFF_FFFF_FFFF_FFFF);

    // Reset asserted between clock edges while chunk 3 is being added.
    bus.a = 64'h1234_5678_9ABC_DEF0;
    bus.b = 64'h0FED_CBA9_8765_4321;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset in_ready",  64'(bus.in_ready),  64'd1);
    check("midreset out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset sum",       bus.sum,            64'd0);
    check("midreset flags",     64'(dut_flags()),   64'd0);
    saw_valid = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) rst_n = 1'b1;
      tick();
      if (bus.out_valid) saw_valid++;
    end
    check("midreset no out_valid pulse", 64'(saw_valid), 64'd0);
    run_op("5+7 after reset", 64'd5, 64'd7, 0, 1'b0);
    check("5+7 value", bus.sum, 64'd12);

    for (int n = 0; n < 24; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case (n % 4)
        1: rb = -ra;
        2: rb = {1'b0, ra[63] ? 63'h0 : 63'h7FFF_FFFF_FFFF_FFFF};
        default: ;
      endcase
      run_op($sformatf("rand%0d", n), ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
